// File: rtl/sub_serial_pkg.sv
// rtl/sub_serial_pkg.sv - shared state encoding and width helper for the serial subtractor
package sub_serial_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_serial_n_dff.sv
// rtl/sub_serial_n_dff.sv - W-bit register with synchronous active-high reset
module dff_n #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) q_o <= '0;
    else       q_o <= d_i;
  end

endmodule

// File: rtl/sub_serial_n_fs_1bit.sv
// rtl/sub_serial_n_fs_1bit.sv - combinational 1-bit full subtractor cell (a - b - bin)
module FS_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_serial_n.sv
// rtl/sub_serial_n.sv - bit-serial N-bit subtractor, LSB first, start/ready/done handshake
// Optional signed overflow output ovf_o enabled by SUB_SIGNED_OVF_EN.
module sub_serial_n
  import sub_serial_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] data0_i,
  input  logic [N-1:0] data1_i,
  output logic         ready_o,
  output logic         done_o,
  output logic [N-1:0] diff_o,
`ifdef SUB_SIGNED_OVF_EN
  output logic         ovf_o,
`endif
  output logic         borrow_o
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  sub_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic          borrow_q, borrow_d;
  logic          br_q, br_d;
  logic          fs_d, fs_bout;

  FS_1bit u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  dff_n #(.W(1)) u_br (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (br_d),
    .q_o   (br_q)
  );

`ifdef SUB_SIGNED_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    br_d     = br_q;
`ifdef SUB_SIGNED_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = data0_i;
          b_d     = data1_i;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SUB_SIGNED_OVF_EN
          a_msb_d = data0_i[N-1];
          b_msb_d = data1_i[N-1];
`endif
        end
      end
      RUN: begin
        // Result fills from the top so bit 0 lands in the LSB after N shifts.
        res_d        = res_q >> 1;
        res_d[N-1]   = fs_d;
        a_d          = a_q >> 1;
        b_d          = b_q >> 1;
        br_d         = fs_bout;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          borrow_d = fs_bout;
`ifdef SUB_SIGNED_OVF_EN
          ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ fs_d);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
`ifdef SUB_SIGNED_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign done_o   = (state_q == DONE);
  assign diff_o   = res_q;
  assign borrow_o = borrow_q;
`ifdef SUB_SIGNED_OVF_EN
  assign ovf_o    = ovf_q;
`endif

endmodule

// File: tb/tb_sub_serial_n.sv
// tb/tb_sub_serial_n.sv - scoreboard bench for sub_serial_n (N=8, plus N=1 under SUB_SIGNED_OVF_EN)
module tb_sub_serial_n;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [7:0] data0, data1;
  logic       ready_o, done_o, borrow_o;
  logic [7:0] diff_o;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  sub_serial_n #(.N(8)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .data0_i  (data0),
    .data1_i  (data1),
    .ready_o  (ready_o),
    .done_o   (done_o),
    .diff_o   (diff_o),
`ifdef SUB_SIGNED_OVF_EN
    .ovf_o    (ovf),
`endif
    .borrow_o (borrow_o)
  );

`ifndef SUB_SIGNED_OVF_EN
  assign ovf = 1'b0;
`else
  logic start1, d0_1, d1_1, ready1, done1, diff1, borrow1, ovf1;
  sub_serial_n #(.N(1)) dut1 (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .start_i  (start1),
    .data0_i  (d0_1),
    .data1_i  (d1_1),
    .ready_o  (ready1),
    .done_o   (done1),
    .diff_o   (diff1),
    .ovf_o    (ovf1),
    .borrow_o (borrow1)
  );
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst_i && done_o) begin
      logic [9:0] e;
      done_cnt++;
      chk("ready_with_done", ready_o, 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("diff", diff_o, e[7:0]);
        chk("borrow", borrow_o, e[8]);
`ifdef SUB_SIGNED_OVF_EN
        chk("ovf", ovf, e[9]);
`endif
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 50) begin @(negedge clk); n++; end
    chk("ready_wait", ready_o, 1);
  endtask

  task automatic wait_done(output int edges);
    edges = 1;
    while (!done_o && edges < 50) begin @(posedge clk); #1; edges++; end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb, input logic eo);
    int n;
    wait_ready();
    data0 = a; data1 = b; start_i = 1'b1;
    sb.push_back({eo, eb, ed});
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("ready_drop", ready_o, 0);
    wait_done(n);
    chk("done_edge", n, 9);
    @(negedge clk);
  endtask

  initial begin
    int n, dc;
    rst_i = 1'b1; start_i = 1'b0; data0 = '0; data1 = '0;
`ifdef SUB_SIGNED_OVF_EN
    start1 = 1'b0; d0_1 = 1'b0; d1_1 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    chk("rst_ready", ready_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_diff", diff_o, 8'h00);
    chk("rst_borrow", borrow_o, 0);

    do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    do_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_diff", diff_o, 8'hFE);
      chk("hold_borrow", borrow_o, 1);
    end
    do_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    do_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    do_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);

    // Start pulse during RUN must be ignored.
    wait_ready();
    dc = done_cnt;
    data0 = 8'h10; data1 = 8'h01; start_i = 1'b1;
    sb.push_back({1'b0, 1'b0, 8'h0F});
    @(posedge clk); #1; start_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    data0 = 8'h00; data1 = 8'h01; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    wait_done(n);
    chk("midrun_done_seen", done_o, 1);
    repeat (12) @(negedge clk);
    chk("midrun_one_done", done_cnt - dc, 1);

    // Reset at edge 5 aborts without a done pulse.
    wait_ready();
    dc = done_cnt;
    data0 = 8'h33; data1 = 8'h11; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", ready_o, 1);
    chk("abort_done", done_o, 0);
    chk("abort_diff", diff_o, 8'h00);
    chk("abort_borrow", borrow_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    chk("abort_no_done", done_cnt - dc, 0);
    do_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

    do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    do_op(8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0);

`ifdef SUB_SIGNED_OVF_EN
    d0_1 = 1'b0; d1_1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    n = 1;
    while (!done1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("n1_done_edge", n, 2);
    chk("n1_diff", diff1, 1);
    chk("n1_borrow", borrow1, 1);
    chk("n1_ovf", ovf1, 1);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub_serial_n.md
Name: sub_serial_n

Overview:
- Bit-serial N-bit subtractor that computes diff = data0 - data1, one bit per clock, LSB first.
- Built around a 1-bit full-subtractor cell; it is the inverse-operation counterpart of the team's ripple adder.
- Used where area matters more than latency, for example address/pointer difference and compare in slow control paths.
- Start/ready/done handshake with registered, held results.

Parameters:
- N, 8, operand/result width in bits (N >= 1).

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request a subtraction; accepted only while ready_o = 1.
- data0_i  input  N  minuend, sampled on the accepting edge.
- data1_i  input  N  subtrahend, sampled on the accepting edge.
- ready_o  output  1  block idle, can accept start_i.
- done_o  output  1  one-cycle pulse: diff_o/borrow_o valid.
- diff_o  output  N  data0 - data1 mod 2^N; held until the next accepted start.
- borrow_o  output  1  final borrow (1 when data0 < data1 unsigned); held with diff_o.

Behaviour:
- Clock and reset: one clock clk_i; reset is synchronous and active-high (rst_i).
- Reset values: state = IDLE, ready_o = 1, done_o = 0, diff_o = 0, borrow_o = 0, bit counter = 0, internal borrow = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_o = 1.
  - On start_i = 1: latch data0_i/data1_i into shift registers A/B, clear the borrow flop and the counter, go to RUN.
  - diff_o/borrow_o keep their previous values until the first RUN edge overwrites them.
- RUN: each edge processes bit i = counter using the current A[0], B[0] and borrow br:
  - d = A[0]^B[0]^br
  - br' = (~A[0]&B[0]) | (~(A[0]^B[0])&br)
  - The result register shifts right with d entering the MSB; A and B shift right; counter increments.
  - After the edge that processes bit N-1, go to DONE and set borrow_o = br'.
- DONE:
  - done_o = 1 for exactly this one cycle; ready_o = 0.
  - The next edge returns to IDLE unconditionally.
- Latency: counting the start-accepting edge as edge 1, done_o is high in the cycle after edge N+1 (N = 8: after the 9th edge).
  - Throughput is one operation per N+2 cycles.
- start_i while in RUN or DONE: ignored; the operands in flight are unaffected.
- start_i held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- ready_o and done_o are never high together.
- Mid-operation rst_i: abort immediately on that edge; all outputs return to reset values and no done_o pulse is issued.
- Width rules:
  - Counter width is max(1, $clog2(N)).
  - N = 1: RUN lasts one edge; counter terminal value is 0.
- diff_o during RUN holds partial shift contents. It is only meaningful in DONE or in IDLE after a completed operation.

Optional Feature:
- Macro SUB_SIGNED_OVF_EN.
- Defined:
  - Extra output ovf_o (1 bit), computed on the edge that enters DONE and held with diff_o.
  - ovf_o = (a[N-1]^b[N-1]) & (a[N-1]^diff[N-1]), i.e. two's-complement signed overflow of the operands.
  - a[N-1]/b[N-1] are the operand MSBs, captured at the accepting edge.
  - Reset value 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package sub_serial_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t; localparam-free helper function cnt_w(N) returning counter width.
- Sub-module FS_1bit: combinational full subtractor, ports a, b, bin, d, bout; one instance in the datapath.
- The borrow flop reuses the team's dff_n register with a synchronous-reset variant.

Test Plan:
- N = 8, 0x05 - 0x03, start pulse: ready_o drops next cycle; done_o after 9th edge; diff_o = 0x02, borrow_o = 0.
- 0x03 - 0x05: diff_o = 0xFE, borrow_o = 1, held stable for 5 idle cycles after done.
- Boundaries:
  - 0x00 - 0x00 -> 0x00/0.
  - 0xFF - 0x00 -> 0xFF/0.
  - 0x00 - 0xFF -> 0x01/1.
- Start during RUN: start 0x10 - 0x01, then pulse start_i with 0x00 - 0x01 at edge 4 -> result 0x0F/0, only one done_o pulse.
- rst_i asserted at edge 5 of an operation: next cycle ready_o = 1, done_o = 0, diff_o = 0x00, borrow_o = 0; a new 0x09 - 0x04 then yields 0x05.
- With SUB_SIGNED_OVF_EN:
  - 0x80 - 0x01 -> diff 0x7F, ovf_o = 1.
  - 0x7F - 0x01 -> 0x7E, ovf_o = 0.
  - N = 1 build: 0 - 1 -> diff 1, borrow 1, done after 2nd edge.
